alu_mul_sequencer: RTL and testbench

//  Multi-cycle unsigned multiplier controller built on the shared 64-bit ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_sequencer_if.sv | 32 +++
 rtl/alu_mul_sequencer.sv | 165 ++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default width and the
// multiplier sequencer state type.
package alu_pkg;

  localparam int unsigned ALU_W = 64;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Borrowed-ALU bus: request/grant handshake plus operands, opcode, result.
// master = the block driving the ALU, slave = arbiter/ALU side.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 64
);

  logic             alu_req;
  logic             alu_gnt;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output alu_req,
    output alu_a,
    output alu_b,
    output alu_op,
    input  alu_gnt,
    input  alu_result
  );

  modport slave (
    input  alu_req,
    input  alu_a,
    input  alu_b,
    input  alu_op,
    output alu_gnt,
    output alu_result
  );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier borrowing the shared ALU per cycle.
// Ports: clk, reset (sync, high), start/op_a/op_b in, busy/done/product out, alu bus (master).
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int         WIDTH  = ALU_W,
  parameter logic [3:0] OP_ADD = ALU_ADD,
  parameter logic [3:0] OP_SLL = ALU_SLL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     product,
  alu_mul_sequencer_if.master  alu
);

  localparam int CW = $clog2(WIDTH);

  mul_state_t state_q, state_d;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] mplier_sh;
  logic             last_shift;

  assign mplier_sh  = mplier_q >> 1;
  // Stop once no multiplier bits remain, or after the last bit position.
  assign last_shift = (mplier_sh == '0) ||
                      (cnt_q == CW'(WIDTH - 1));

  // FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (op_b == '0) begin
            state_d = DONE;
          end else if (op_b[0]) begin
            state_d = ADD;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      ADD: begin
        if (alu.alu_gnt) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (alu.alu_gnt) begin
          if (last_shift) begin
            state_d = DONE;
          end else if (mplier_q[1]) begin
            state_d = ADD;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
        end
      end
      ADD: begin
        if (alu.alu_gnt) begin
          acc_d = alu.alu_result;
        end
      end
      SHIFT: begin
        if (alu.alu_gnt) begin
          mcand_d  = alu.alu_result;
          mplier_d = mplier_sh;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      default: begin
      end
    endcase
    // Capture on entry to DONE so product is valid alongside the pulse.
    product_d = (state_d == DONE) ? acc_d : product_q;
  end

  // ALU drive
  always_comb begin
    alu.alu_req = 1'b0;
    alu.alu_a   = '0;
    alu.alu_b   = '0;
    alu.alu_op  = OP_ADD;
    unique case (state_q)
      ADD: begin
        alu.alu_req = 1'b1;
        alu.alu_a   = acc_q;
        alu.alu_b   = mcand_q;
        alu.alu_op  = OP_ADD;
      end
      SHIFT: begin
        alu.alu_req = 1'b1;
        alu.alu_a   = mcand_q;
        alu.alu_b   = WIDTH'(1);
        alu.alu_op  = OP_SLL;
      end
      default: begin
      end
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural ALU,
// grant-counting latency model and randomized operands/grants.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done;
  logic [W-1:0] product;
  logic         gnt = 1'b1;

  alu_mul_sequencer_if #(.WIDTH(W)) bus ();

  alu_mul_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .alu     (bus)
  );

  always #5 clk = ~clk;

  assign bus.alu_gnt = gnt;

  always_comb begin
    bus.alu_result = '0;
    if (bus.alu_op == ALU_ADD)
      bus.alu_result = bus.alu_a + bus.alu_b;
    else if (bus.alu_op == ALU_SLL)
      bus.alu_result = bus.alu_a << bus.alu_b[5:0];
  end

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb_q[$];

  int           cyc = 0;
  bit           m_busy = 0;
  int           m_need = 0;
  int           m_got = 0;
  logic [W-1:0] m_val = '0;
  logic [W-1:0] m_prod = '0;
  bit           mon_en = 0;
  bit           gnt_rand = 0;
  int           hold_cnt = 0;

  // ALU cycles required: one ADD per set bit plus one SHIFT per
  // position up to and including the top set bit.
  function automatic int need(logic [W-1:0] b);
    int ones = 0;
    int msb = 0;
    if (b == '0) return 0;
    for (int i = 0; i < W; i++)
      if (b[i]) begin
        ones++;
        msb = i;
      end
    return ones + msb + 1;
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: counts granted ALU cycles per operation.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_busy = 0;
      m_prod = '0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1;
        m_need = need(op_b);
        m_got  = 0;
        m_val  = op_a * op_b;
        if (m_need == 0) m_prod = m_val;
      end
    end else if (m_got == m_need) begin
      m_busy = 0;
    end else if (gnt) begin
      m_got++;
      if (m_got == m_need) m_prod = m_val;
    end
  end

  // Grant generator
  always @(posedge clk) begin
    #2;
    if (hold_cnt > 0) begin
      gnt = 1'b0;
      hold_cnt--;
    end else if (gnt_rand) begin
      gnt = ($urandom_range(0, 9) < 7);
    end else begin
      gnt = 1'b1;
    end
  end

  bit           snap_v = 0;
  logic [W-1:0] snap_a, snap_b;
  logic [3:0]   snap_op;

  // Monitor
  always @(negedge clk) begin
    bit m_alu, m_dn;
    logic [W-1:0] exp;
    if (mon_en) begin
      m_alu = m_busy && (m_got < m_need);
      m_dn  = m_busy && (m_got == m_need);
      check("busy", W'(busy), W'(m_busy));
      check("done", W'(done), W'(m_dn));
      check("alu_req", W'(bus.alu_req), W'(m_alu));
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
        end else begin
          exp = sb_q.pop_front();
          check("product", product, exp);
        end
      end else begin
        check("product_hold", product, m_prod);
      end
      if (!m_alu) begin
        check("idle_alu_a", bus.alu_a, '0);
        check("idle_alu_b", bus.alu_b, '0);
        check("idle_alu_op", W'(bus.alu_op), W'(ALU_ADD));
      end
      if (snap_v && m_alu) begin
        check("stall_alu_a", bus.alu_a, snap_a);
        check("stall_alu_b", bus.alu_b, snap_b);
        check("stall_alu_op", W'(bus.alu_op), W'(snap_op));
      end
      snap_v  = m_alu && !gnt;
      snap_a  = bus.alu_a;
      snap_b  = bus.alu_b;
      snap_op = bus.alu_op;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 3000 && m_busy; i++) @(negedge clk);
    if (m_busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy after 3000 cycles expected idle");
    end
  endtask

  task automatic do_op(logic [W-1:0] a, logic [W-1:0] b,
                       int hold, bit push);
    wait_idle();
    @(posedge clk);
    #1;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    if (push) sb_q.push_back(a * b);
    @(posedge clk);
    #1;
    start    = 1'b0;
    hold_cnt = hold;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    int r;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_product", product, '0);
    check("rst_alu_req", W'(bus.alu_req), '0);
    check("rst_alu_a", bus.alu_a, '0);
    check("rst_alu_b", bus.alu_b, '0);
    check("rst_alu_op", W'(bus.alu_op), W'(ALU_ADD));
    mon_en = 1;

    do_op(64'd3, 64'd5, 0, 1);
    do_op(64'hDEAD, 64'd0, 0, 1);
    do_op(64'h8000_0000_0000_0000, 64'd2, 0, 1);
    do_op('1, '1, 0, 1);
    do_op(64'd7, 64'd6, 3, 1);

    // Reset mid-operation: the pending result is dropped.
    do_op(64'd9, 64'd9, 0, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb_q.delete();
    do_op(64'd4, 64'd4, 0, 1);

    // Second start while busy must be ignored.
    do_op(64'd5, 64'd3, 0, 1);
    @(posedge clk);
    #1 start = 1'b1;
    op_a = 64'd1;
    op_b = 64'd1;
    @(posedge clk);
    #1 start = 1'b0;

    gnt_rand = 1;
    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom};
      r = $urandom_range(0, 3);
      case (r)
        0: b = W'($urandom_range(0, 15));
        1: b = {$urandom, $urandom};
        2: b = W'(1) << $urandom_range(0, 63);
        default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      do_op(a, b, 0, 1);
    end
    gnt_rand = 0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_empty", W'(sb_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
